// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit : queued load/store front end for a single-port data RAM |
// |   optional address protection with `define LSU_FAULT_EN  -- Rev 1.0      |
// +--------------------------------------------------------------------------+
module load_store_unit #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] PROT_BASE  = 'hF0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_enable_write,
   output logic              mem_enable_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t state, state_next;

   logic              q_we    [FIFO_DEPTH];
   logic [ADDR_W-1:0] q_addr  [FIFO_DEPTH];
   logic [DATA_W-1:0] q_wdata [FIFO_DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic [PTR_W-1:0] wr_idx, rd_idx;
   logic             full, empty, push, pop;
   logic             cur_we, cur_fault, head_fault;

   assign wr_idx    = wr_ptr[PTR_W-1:0];
   assign rd_idx    = rd_ptr[PTR_W-1:0];
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign pop       = (state == IDLE) && !empty;

`ifdef LSU_FAULT_EN
   assign head_fault = (q_addr[rd_idx] >= PROT_BASE);
`else
   logic prot_unused;
   assign head_fault  = 1'b0;
   assign prot_unused = ^PROT_BASE;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         q_we[wr_idx]    <= req_we;
         q_addr[wr_idx]  <= req_addr;
         q_wdata[wr_idx] <= req_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // mem_addr/mem_wdata double as the popped-entry register, so they hold
   // their value outside ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_we    <= 1'b0;
         cur_fault <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_next;
         if (pop) begin
            cur_we    <= q_we[rd_idx];
            cur_fault <= head_fault;
            mem_addr  <= q_addr[rd_idx];
            mem_wdata <= q_wdata[rd_idx];
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!empty) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (state == ACCESS) begin
         resp_rdata <= (cur_we || cur_fault) ? '0 : mem_rdata;
         resp_err   <= cur_fault;
      end
   end

   assign mem_enable_write = (state == ACCESS) &&  cur_we && !cur_fault;
   assign mem_enable_read  = (state == ACCESS) && !cur_we && !cur_fault;
   assign resp_valid       = (state == RESP);
   assign busy             = (state != IDLE) || !empty;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_store_unit : self-checking bench with RAM model and scoreboard   |
// |   Rev 1.0                                                                |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

   localparam logic [7:0] PBASE = 8'hF0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [7:0] req_addr = '0, req_wdata = '0;
   logic       resp_valid, resp_ready = 1'b0, resp_err;
   logic [7:0] resp_rdata;
   logic       mem_enable_write, mem_enable_read;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   load_store_unit #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(2), .PROT_BASE(PBASE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_enable_write(mem_enable_write), .mem_enable_read(mem_enable_read),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input logic [7:0] a);
      if (a == 8'h00) return 8'h48;
      if (a == 8'h01) return 8'h08;
      return a ^ 8'hA5;
   endfunction

   function automatic logic is_fault(input logic [7:0] a);
`ifdef LSU_FAULT_EN
      return a >= PBASE;
`else
      return (a == 8'h00) && (a != 8'h00);
`endif
   endfunction

   // Data RAM: combinational read, write on the rising edge.
   logic [7:0] ram [256];
   assign mem_rdata = ram[mem_addr];
   initial begin
      for (int i = 0; i < 256; i++) ram[i] = init_val(8'(i));
      forever begin
         @(posedge clk);
         if (mem_enable_write) ram[mem_addr] = mem_wdata;
      end
   end

   logic [7:0] ref_mem [256];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One isolated request from an idle unit, checking cycle-exact behaviour.
   task automatic single(input logic we, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] erd, input logic eerr);
      logic flt;
      flt = is_fault(a);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; resp_ready = 1'b0;
      chk("idle_ready", req_ready, 1);
      tick;
      req_valid = 1'b0;
      chk("queued_busy", busy, 1);
      chk("no_early_resp", resp_valid, 0);
      tick;
      chk("acc_en_w", mem_enable_write, we && !flt);
      chk("acc_en_r", mem_enable_read, !we && !flt);
      chk("acc_addr", mem_addr, a);
      if (we) chk("acc_wdata", mem_wdata, wd);
      chk("acc_no_resp", resp_valid, 0);
      tick;
      chk("resp_valid", resp_valid, 1);
      chk("resp_en_off", {mem_enable_write, mem_enable_read}, 0);
      chk("resp_rdata", resp_rdata, erd);
      chk("resp_err", resp_err, eerr);
      chk("hold_addr", mem_addr, a);
      tick;
      chk("resp_hold_valid", resp_valid, 1);
      chk("resp_hold_rdata", resp_rdata, erd);
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk("resp_done", resp_valid, 0);
      chk("idle_busy", busy, 0);
      if (we && !flt) ref_mem[a] = wd;
   endtask

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   vec_t vecs [10];

   typedef struct {
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   exp_t sb [$];

   initial begin
      int got;
      int acc_cnt, en_cnt, exp_en;
      logic acc_pat [4];
      logic [7:0] exp_bp [3];
      logic hold, never_resp;
      logic [7:0] prev_rd;
      logic prev_err;
      exp_t e;

      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

      vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h48, 1'b0};
      vecs[1] = '{1'b0, 8'h01, 8'h00, 8'h08, 1'b0};
      vecs[2] = '{1'b1, 8'h10, 8'h5A, 8'h00, 1'b0};
      vecs[3] = '{1'b0, 8'h10, 8'h00, 8'h5A, 1'b0};
      vecs[5] = '{1'b0, 8'hEF, 8'h00, 8'h4A, 1'b0};
      vecs[7] = '{1'b1, 8'h20, 8'hFF, 8'h00, 1'b0};
      vecs[8] = '{1'b0, 8'h20, 8'h00, 8'hFF, 1'b0};
      vecs[9] = '{1'b1, 8'h21, 8'h3C, 8'h00, 1'b0};
`ifdef LSU_FAULT_EN
      vecs[4] = '{1'b1, 8'hF4, 8'h77, 8'h00, 1'b1};
      vecs[6] = '{1'b0, 8'hF4, 8'h00, 8'h00, 1'b1};
`else
      vecs[4] = '{1'b1, 8'hF4, 8'h77, 8'h00, 1'b0};
      vecs[6] = '{1'b0, 8'hF4, 8'h00, 8'h77, 1'b0};
`endif

      // Reset state
      #12;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_enables", {mem_enable_write, mem_enable_read}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors; the first is accepted on the first edge out of reset
      for (int v = 0; v < 10; v++)
         single(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata, vecs[v].exp_err);
`ifdef LSU_FAULT_EN
      single(1'b0, 8'hF0, 8'h00, 8'h00, 1'b1);
`else
      single(1'b0, 8'hF0, 8'h00, 8'h55, 1'b0);
`endif

      // Back-pressure: four loads offered with resp_ready low
      resp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30 + 8'(k);
         acc_pat[k] = req_ready;
         tick;
      end
      req_valid = 1'b0;
      chk("bp_accept_pattern", {acc_pat[0], acc_pat[1], acc_pat[2], acc_pat[3]}, 4'b1110);
      chk("bp_full_ready", req_ready, 0);
      for (int k = 0; k < 3; k++) exp_bp[k] = ref_mem[8'h30 + 8'(k)];
      resp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 3; c++) begin
         if (resp_valid) begin
            chk("bp_resp_rdata", resp_rdata, exp_bp[got]);
            got++;
         end
         tick;
      end
      chk("bp_resp_count", got, 3);
      tick; tick;
      chk("bp_ready_back", req_ready, 1);
      chk("bp_idle", busy, 0);
      resp_ready = 1'b0;

      // Asynchronous reset during the ACCESS cycle of a load
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
      tick;
      req_valid = 1'b0;
      tick;
      chk("ar_in_access", mem_enable_read, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_enables", {mem_enable_write, mem_enable_read}, 0);
      chk("ar_resp_valid", resp_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_ready", req_ready, 1);
      tick; tick;
      rst_n = 1'b1;
      resp_ready = 1'b1;
      never_resp = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (resp_valid || busy) never_resp = 1'b0;
         tick;
      end
      chk("ar_no_response", never_resp, 1);

      // Randomised traffic against the reference model
      acc_cnt = 0; en_cnt = 0; exp_en = 0; hold = 1'b0; prev_rd = '0; prev_err = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (c < 500) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = {(($urandom_range(0, 3) == 0) ? 4'hF : 4'h4), 4'($urandom_range(0, 15))};
            req_wdata = 8'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
         end else begin
            req_valid = 1'b0;
            resp_ready = 1'b1;
         end
         @(negedge clk);
         if (mem_enable_write && mem_enable_read) chk("rnd_enable_excl", 1, 0);
         if (mem_enable_write || mem_enable_read) en_cnt++;
         if (hold) begin
            chk("rnd_hold_valid", resp_valid, 1);
            chk("rnd_hold_data", {resp_err, resp_rdata}, {prev_err, prev_rd});
         end
         hold = resp_valid && !resp_ready;
         prev_rd = resp_rdata; prev_err = resp_err;
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) chk("rnd_spurious_resp", 1, 0);
            else begin
               e = sb.pop_front();
               chk("rnd_resp", {resp_err, resp_rdata}, {e.err, e.rdata});
            end
         end
         if (req_valid && req_ready) begin
            acc_cnt++;
            if (is_fault(req_addr)) e = '{8'h00, 1'b1};
            else begin
               exp_en++;
               if (req_we) begin
                  ref_mem[req_addr] = req_wdata;
                  e = '{8'h00, 1'b0};
               end else e = '{ref_mem[req_addr], 1'b0};
            end
            sb.push_back(e);
         end
         @(posedge clk); #1;
      end
      chk("rnd_drained", sb.size(), 0);
      chk("rnd_access_count", en_cnt, exp_en);
      chk("rnd_final_busy", busy, 0);
      if (acc_cnt < 50) chk("rnd_accepts", acc_cnt, 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (low = reset, no synchronisation to clk).
REQ-002 SHALL have these parameters:
- ADDR_W, 8: address width.
- DATA_W, 8: data width.
- FIFO_DEPTH, 2: request queue entries (power of 2, >=2).
- PROT_BASE, 8'hF0: first protected address (used only under REQ-022).
REQ-003 SHALL have these ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request queue not full.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_rdata  out  DATA_W  load data (0 for stores).
- resp_err  out  1  access faulted.
- mem_enable_write  out  1  to data memory enable_write.
- mem_enable_read  out  1  to data memory enable_read.
- mem_addr  out  ADDR_W  to data memory ram_addr.
- mem_wdata  out  DATA_W  to data memory write_data.
- mem_rdata  in  DATA_W  from data memory read_data (combinational).
- busy  out  1  state != IDLE or queue non-empty.

Function
REQ-004 SHALL accept a request on a rising edge where req_valid && req_ready; accepted requests are queued FIFO, in order.
REQ-005 SHALL drive req_ready = !full combinationally; no push when full, even if a pop occurs in the same cycle.
REQ-006 SHALL implement FSM IDLE, ACCESS, RESP.
- IDLE: if the queue is non-empty, pop the head and go to ACCESS; else stay.
- ACCESS: exactly one cycle, then RESP.
- RESP: hold until resp_ready, then IDLE.
REQ-007 SHALL register the popped entry; during ACCESS, mem_addr/mem_wdata SHALL equal that entry.
REQ-008 In ACCESS, SHALL assert mem_enable_write for a store or mem_enable_read for a load, for exactly one cycle; both enables SHALL be 0 in all other states.
REQ-009 SHALL never assert mem_enable_write and mem_enable_read together.
REQ-010 SHALL capture mem_rdata into resp_rdata at the edge leaving ACCESS for a load, and load 0 for a store.
REQ-011 Every accepted request SHALL produce exactly one response, in order.
REQ-012 resp_valid SHALL be 1 only in RESP and SHALL rise two edges after the accepting edge when the FSM is IDLE and the queue is empty at acceptance.
REQ-013 resp_rdata/resp_err SHALL be stable while resp_valid && !resp_ready.
REQ-014 SHALL keep accepting requests during ACCESS and RESP until the queue is full.
REQ-015 Throughput SHALL be one access per 3 cycles with resp_ready held high.
REQ-016 Queue pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or a count.
REQ-017 mem_addr/mem_wdata SHALL hold their last value outside ACCESS.

Reset
REQ-018 While rst_n is low, SHALL immediately force: state IDLE, queue empty, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, both mem enables 0, mem_addr 0, mem_wdata 0, busy 0.
REQ-019 Reset mid-operation SHALL discard in-flight and queued requests with no response.
REQ-020 The first accept after reset SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-021 SHALL use macro LSU_FAULT_EN.
REQ-022 With LSU_FAULT_EN defined, a request with addr >= PROT_BASE SHALL pass through ACCESS with both mem enables 0, then respond resp_err=1, resp_rdata=0.
REQ-023 Without LSU_FAULT_EN, resp_err SHALL be tied 0, all addresses SHALL be accessed, and PROT_BASE SHALL be unused.

Verification
REQ-024 Store 0x5A to 0x10, then load 0x10 -> mem_enable_write high one cycle with mem_addr=0x10, mem_wdata=0x5A; load resp_rdata=0x5A, resp_err=0.
REQ-025 After reset, load 0x00 -> resp_valid two edges after accept, resp_rdata=0x48; load 0x01 -> 0x08.
REQ-026 resp_ready=0, offer 4 loads back-to-back -> 3 accepted (1 in RESP, 2 queued), then req_ready=0; release resp_ready -> 3 responses in order, req_ready returns 1.
REQ-027 LSU_FAULT_EN defined, store 0x77 to 0xF4 -> no mem enable, resp_err=1, rdata=0x00, later load 0xF4 also faults; without the macro -> normal write and read back 0x77.
REQ-028 Drop rst_n during ACCESS of a load -> enables and resp_valid 0 at once, no response after release, busy=0, req_ready=1.
